// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: stretches reset until PLL lock is stable, then releases
// per-domain resets in order. Optional sticky reset-cause register via RESET_SEQ_CAUSE_EN.
module reset_sequencer #(
  parameter int unsigned NumStages     = 3,
  parameter int unsigned HoldCycles    = 16,
  parameter int unsigned StageGap      = 4,
  parameter int unsigned LockSyncDepth = 2
) (
  input  logic                 clk,
  input  logic                 reset_in,
  input  logic                 lock_in,
  input  logic                 soft_req,
  output logic [NumStages-1:0] rst_n_out,
  output logic                 ready,
  output logic [1:0]           cause
);

  localparam int unsigned CntMax = (HoldCycles > StageGap) ? HoldCycles : StageGap;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;
  localparam int unsigned IdxW   = $clog2(NumStages + 1);

  localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(StageGap - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NumStages - 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT_LOCK,
    S_STRETCH,
    S_RELEASE,
    S_RUN
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [NumStages-1:0]   rst_q, rst_d;
  logic                   ready_q, ready_d;
  logic [LockSyncDepth-1:0] sync_q;

  logic lock_s;
  logic busy;
  logic lock_loss;
  logic soft_hit;

  // Lock synchronizer: lock_in is asynchronous to clk.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) sync_q <= '0;
    else           sync_q <= {sync_q[LockSyncDepth-2:0], lock_in};
  end

  assign lock_s    = sync_q[LockSyncDepth-1];
  assign busy      = (state_q == S_STRETCH) || (state_q == S_RELEASE) || (state_q == S_RUN);
  assign lock_loss = busy && !lock_s;
  assign soft_hit  = busy && lock_s && soft_req;

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ready_d = ready_q;

    case (state_q)
      S_HOLD: state_d = S_WAIT_LOCK;

      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STRETCH;
          cnt_d   = '0;
        end
      end

      S_STRETCH: begin
        if (cnt_q == HoldLast) begin
          rst_d[0] = 1'b1;
          cnt_d    = '0;
          idx_d    = IdxW'(1);
          if (NumStages == 1) begin
            state_d = S_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = S_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      S_RELEASE: begin
        if (cnt_q == GapLast) begin
          for (int k = 0; k < NumStages; k++) begin
            if (idx_q == IdxW'(k)) rst_d[k] = 1'b1;
          end
          idx_d = idx_q + IdxW'(1);
          cnt_d = '0;
          if (idx_q == IdxLast) begin
            state_d = S_RUN;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      S_RUN: ;

      default: state_d = S_HOLD;
    endcase

    // Lock loss outranks a simultaneous soft request.
    if (lock_loss) begin
      state_d = S_WAIT_LOCK;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '0;
      ready_d = 1'b0;
    end else if (soft_hit) begin
      state_d = S_STRETCH;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '0;
      ready_d = 1'b0;
    end
  end

  assign rst_n_out = rst_q;
  assign ready     = ready_q;

`ifdef RESET_SEQ_CAUSE_EN
  logic [1:0] cause_q, cause_d;

  always_comb begin
    cause_d = cause_q;
    if (lock_loss)     cause_d = 2'b01;
    else if (soft_hit) cause_d = 2'b10;
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) cause_q <= 2'b00;
    else           cause_q <= cause_d;
  end

  assign cause = cause_q;
`else
  assign cause = 2'b00;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a timeline-based reference model predicts
// outputs per edge; a negedge monitor pops and compares.
module tb_reset_sequencer;
  localparam int N    = 3;
  localparam int HOLD = 16;
  localparam int GAP  = 4;
  localparam int SD   = 2;

  logic         clk = 1'b0;
  logic         reset_in;
  logic         lock_in;
  logic         soft_req;
  logic [N-1:0] rst_n_out;
  logic         ready;
  logic [1:0]   cause;

  reset_sequencer #(
    .NumStages(N), .HoldCycles(HOLD), .StageGap(GAP), .LockSyncDepth(SD)
  ) dut (
    .clk(clk), .reset_in(reset_in), .lock_in(lock_in), .soft_req(soft_req),
    .rst_n_out(rst_n_out), .ready(ready), .cause(cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] rst;
    logic         rdy;
    logic [1:0]   cs;
  } exp_t;

  exp_t exq[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: "sequencing since edge m_start" with lock seen SD edges late.
  bit         m_hold;
  bit         m_wait;
  int         m_start;
  int         m_edge;
  logic [1:0] m_cause;
  bit         hist[$];

  task automatic model_reset();
    m_hold  = 1;
    m_wait  = 0;
    m_cause = 2'b00;
    hist    = {};
    for (int i = 0; i < SD; i++) hist.push_back(1'b0);
  endtask

  task automatic model_edge(input logic rin, input logic lk, input logic sr, output exp_t e);
    int n;
    int el;
    bit ls;
    e = '0;
    if (!rin) begin
      model_reset();
      return;
    end
    ls = hist[SD-1];
    hist.push_front(lk);
    void'(hist.pop_back());
    m_edge++;
    if (m_hold) begin
      m_hold = 0;
      m_wait = 1;
    end else if (m_wait) begin
      if (ls) begin
        m_wait  = 0;
        m_start = m_edge;
      end
    end else if (!ls) begin
      m_wait  = 1;
      m_cause = 2'b01;
    end else if (sr) begin
      m_start = m_edge;
      m_cause = 2'b10;
    end
    n = 0;
    if (!m_hold && !m_wait) begin
      el = m_edge - m_start;
      if (el >= HOLD) begin
        n = 1 + (el - HOLD) / GAP;
        if (n > N) n = N;
      end
    end
    e.rst = N'((1 << n) - 1);
    e.rdy = (n == N);
`ifdef RESET_SEQ_CAUSE_EN
    e.cs = m_cause;
`else
    e.cs = 2'b00;
`endif
  endtask

  task automatic step(input logic rin, input logic lk, input logic sr);
    exp_t e;
    @(negedge clk);
    #1;
    reset_in = rin;
    lock_in  = lk;
    soft_req = sr;
    model_edge(rin, lk, sr, e);
    exq.push_back(e);
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if (rst_n_out !== '0 || ready !== 1'b0 || cause !== 2'b00) begin
      miscompares++;
      $display("FAIL %s: rst_n_out=%b ready=%b cause=%b, expected all zero", name, rst_n_out, ready, cause);
    end
  endtask

  // Asserts reset between edges and checks outputs clear without a clock edge.
  task automatic areset();
    exp_t e;
    @(negedge clk);
    #1;
    reset_in = 1'b0;
    #1;
    check_zero("async_reset");
    model_edge(1'b0, lock_in, soft_req, e);
    exq.push_back(e);
  endtask

  task automatic run(input int cycles, input logic lk, input logic sr);
    for (int i = 0; i < cycles; i++) step(1'b1, lk, sr);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exq.size() > 0) begin
        e = exq.pop_front();
        vectors++;
        if ({rst_n_out, ready, cause} !== {e.rst, e.rdy, e.cs}) begin
          miscompares++;
          $display("FAIL seq @%0t: rst_n_out=%b ready=%b cause=%b expected %b %b %b",
                   $time, rst_n_out, ready, cause, e.rst, e.rdy, e.cs);
        end
      end
    end
  end

  initial begin : stim
    logic lk;
    reset_in = 1'b0;
    lock_in  = 1'b1;
    soft_req = 1'b0;
    m_edge   = 0;
    m_start  = 0;
    model_reset();
    #1;
    check_zero("reset_state");
    repeat (3) step(1'b0, 1'b1, 1'b0);

    // Power-up with lock already present, through to RUN.
    run(32, 1'b1, 1'b0);
    // Lock loss in RUN, then restore and re-sequence.
    run(6, 1'b0, 1'b0);
    run(34, 1'b1, 1'b0);
    // Single-cycle soft request in RUN.
    step(1'b1, 1'b1, 1'b1);
    run(30, 1'b1, 1'b0);
    // Held soft request keeps restarting the stretch.
    run(5, 1'b1, 1'b1);
    run(30, 1'b1, 1'b0);
    // Soft request overlapping a lock drop, and soft during WAIT_LOCK.
    run(6, 1'b0, 1'b1);
    run(3, 1'b0, 1'b0);
    run(30, 1'b1, 1'b0);

    // Lock low at reset release, raised before edge 10.
    areset();
    repeat (2) step(1'b0, 1'b0, 1'b0);
    run(10, 1'b0, 1'b0);
    run(34, 1'b1, 1'b0);

    // Reset asserted mid-release with rst_n_out == 3'b001.
    areset();
    step(1'b0, 1'b1, 1'b0);
    run(20, 1'b1, 1'b0);
    areset();
    step(1'b0, 1'b1, 1'b0);

    // Randomized traffic.
    lk = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) lk = ~lk;
      if ($urandom_range(0, 399) == 0) areset();
      else step(1'b1, lk, ($urandom_range(0, 49) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    if (exq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Power-on reset sequencer that sits directly downstream of the reset synchronizer. It consumes the synchronized, active-low system reset and a PLL lock indication, and stretches reset until the clock is stable. It then releases a vector of per-domain resets in a fixed order (memory, then peripherals, then core), with a programmable gap between domains. It also re-runs the sequence on PLL lock loss or on a software reset request.

## Interface
- `NumStages`, 3: number of sequenced reset outputs; must be ≥ 1.
- `HoldCycles`, 16: cycles the lock must be continuously valid before stage 0 is released; must be ≥ 1.
- `StageGap`, 4: cycles between releases of consecutive stages; must be ≥ 1.
- `LockSyncDepth`, 2: flops in the internal `lock_in` synchronizer; must be ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `reset_in`  in  1  reset; asynchronous, active-low. Assertion is asynchronous; deassertion is already synchronous to `clk`.
- `lock_in`  in  1  PLL locked, asynchronous to `clk`; synchronized internally.
- `soft_req`  in  1  synchronous software reset request, sampled every edge.
- `rst_n_out`  out  `NumStages`  per-domain active-low resets; bit 0 is released first.
- `ready`  out  1  high when all stages are released.
- `cause`  out  2  last reset cause (see Configuration).

## Operation
- States: HOLD, WAIT_LOCK, STRETCH, RELEASE, RUN. There is one counter `cnt`, of width `$clog2(max(HoldCycles,StageGap))+1`, and a stage index `idx`.
- While `reset_in`=0 (asynchronous):
  - state=HOLD, `cnt`=0, `idx`=0;
  - lock synchronizer cleared to 0;
  - `rst_n_out`=0, `ready`=0, `cause`=2'b00.
- HOLD → WAIT_LOCK on the first edge with `reset_in`=1.
- WAIT_LOCK: on an edge with synchronized lock `lock_s`=1 → STRETCH, `cnt`=0.
- STRETCH: `cnt` increments each edge. On the edge with `cnt`=HoldCycles−1:
  - `rst_n_out[0]`←1, `cnt`←0, `idx`←1;
  - next state is RELEASE, or RUN with `ready`←1 if NumStages=1.
- RELEASE: `cnt` increments each edge. On the edge with `cnt`=StageGap−1:
  - `rst_n_out[idx]`←1, `idx`++, `cnt`←0;
  - if `idx` was NumStages−1, then state←RUN and `ready`←1 on the same edge.
- Released bits stay 1. `rst_n_out` is always thermometer-coded: bit k is 1 only if bits 0..k−1 are 1.
- Lock loss: an edge sampling `lock_s`=0 in STRETCH, RELEASE or RUN does the following:
  - all `rst_n_out`←0, `ready`←0;
  - state←WAIT_LOCK, `cnt`←0, `idx`←0.
- Soft reset: an edge sampling `soft_req`=1 with `lock_s`=1 in STRETCH, RELEASE or RUN does the following:
  - all `rst_n_out`←0, `ready`←0;
  - state←STRETCH, `cnt`←0, `idx`←0.
  - In HOLD or WAIT_LOCK, `soft_req` is ignored.
- Simultaneous lock loss and `soft_req`: lock loss wins and the state goes to WAIT_LOCK.
- A held `soft_req` keeps restarting STRETCH; release begins HoldCycles edges after its last high sample.
- `reset_in` assertion at any time overrides everything, asynchronously.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- `lock_in` to `lock_s` latency: LockSyncDepth edges.
- With the default parameters and `lock_in`=1 before reset release (edge 0 = first edge with `reset_in`=1):
  - `lock_s`=1 after edge 1;
  - STRETCH entered at edge 2;
  - `rst_n_out[0]` rises at edge 18, `[1]` at edge 22, `[2]` and `ready` at edge 26.
- Release of stage 0 is HoldCycles edges after STRETCH entry. Each further stage follows StageGap edges later.
- Lock loss: `lock_in` falls before edge N; `lock_s`=0 after edge N+1; all outputs go to 0 after edge N+2.
- Soft reset sampled at edge N: outputs go to 0 after edge N.

## Configuration
- Macro `RESET_SEQ_CAUSE_EN`.
- Defined: `cause` is a sticky register, updated on the edge where reset is re-applied:
  - 2'b00 = `reset_in`;
  - 2'b01 = lock loss;
  - 2'b10 = soft reset.
  - It holds its value through the re-sequence and in RUN until the next cause.
- Not defined: `cause` is a constant 2'b00 and no cause logic is synthesized.

## Test plan
- Defaults, `lock_in`=1, release `reset_in` → `rst_n_out` 3'b000 → 3'b001 @edge 18 → 3'b011 @22 → 3'b111 and `ready`=1 @26.
- `lock_in`=0 at reset release, raised before edge 10 → STRETCH entered at edge 12; `rst_n_out[0]` rises @28.
- In RUN, drop `lock_in` before edge N → `rst_n_out`=3'b000 and `ready`=0 after edge N+2; `cause`=2'b01 (with macro). Restoring lock re-runs the full sequence.
- In RUN, single-cycle `soft_req` @N → `rst_n_out`=0 after N; `[0]` rises @N+16; `ready` rises @N+24; `cause`=2'b10.
- `soft_req`=1 together with a lock drop → state WAIT_LOCK and `cause`=2'b01; `soft_req` during WAIT_LOCK has no effect.
- Assert `reset_in` mid-RELEASE (`rst_n_out`=3'b001) → all outputs 0 asynchronously with no clock edge; `cause`=2'b00.
